// File: rtl/maj_sweep_pkg.sv
// Shared types and constants for the majority-gate sweep BIST.
package maj_sweep_pkg;
  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_DONE
  } state_t;

  localparam int NUM_VEC = 8;
  localparam int VEC_W   = 3;
  localparam int ERR_W   = 4;
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);
endpackage

// File: rtl/maj_sweep_ctrl_golden.sv
// Reference 3-input majority, independent of the maj under test.
module maj_golden (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic f
);
  assign f = (x & y) | (y & z) | (x & z);
endmodule

// File: rtl/maj_sweep_ctrl.sv
// Exhaustive sweep of all 8 {X,Y,Z} vectors into an external maj,
// comparing its output against a golden majority.
module maj_sweep_ctrl #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Start,
  input  logic       F_i,
  output logic       X_o,
  output logic       Y_o,
  output logic       Z_o,
  output logic       Busy,
  output logic       Done,
  output logic       Pass,
  output logic [3:0] ErrCnt,
  output logic [2:0] FirstFail
);
  import maj_sweep_pkg::*;

  state_t             state;
  logic [VEC_W-1:0]   vec;
  logic [CNT_W-1:0]   cnt;
  logic               exp_f;
  logic               hit;
  logic               miss;
  logic [ERR_W-1:0]   err_nxt;

  // vec is a register, so the drive to maj is glitch-free
  assign {X_o, Y_o, Z_o} = vec;

  maj_golden u_golden (
    .x (vec[2]),
    .y (vec[1]),
    .z (vec[0]),
    .f (exp_f)
  );

  assign hit     = (state == S_APPLY) && (cnt == CNT_W'(DWELL - 1));
  assign miss    = hit && (F_i != exp_f);
  assign err_nxt = ErrCnt + ERR_W'(miss);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= S_IDLE;
      vec       <= '0;
      cnt       <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Pass      <= 1'b0;
      ErrCnt    <= '0;
      FirstFail <= '0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (Start) begin
            state     <= S_APPLY;
            vec       <= '0;
            cnt       <= '0;
            ErrCnt    <= '0;
            FirstFail <= '0;
            Pass      <= 1'b0;
            Busy      <= 1'b1;
          end
        end
        S_APPLY: begin
          if (hit) begin
            ErrCnt <= err_nxt;
            if (miss && (ErrCnt == '0))
              FirstFail <= vec;
            cnt <= '0;
            // last sample's mismatch is folded into Pass here
            if (vec == LAST_VEC) begin
              state <= S_DONE;
              Done  <= 1'b1;
              Pass  <= (err_nxt == '0);
            end else begin
              vec <= vec + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_maj_sweep_ctrl.sv
// Scoreboard bench: DWELL=4 and DWELL=1 controllers with fault models.
module tb_maj_sweep_ctrl;
  typedef struct {
    logic [3:0] err;
    logic [2:0] ff;
    logic       pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start4 = 1'b0;
  logic start1 = 1'b0;
  int   mode = 0;

  logic f4, x4, y4, z4, busy4, done4, pass4;
  logic [3:0] err4;
  logic [2:0] ff4;
  logic f1, x1, y1, z1, busy1, done1, pass1;
  logic [3:0] err1;
  logic [2:0] ff1;

  int checks = 0;
  int errors = 0;
  int ndone4 = 0;
  int ndone1 = 0;
  int bc4 = 0;
  int bc1 = 0;
  exp_t q4[$];
  exp_t q1[$];
  exp_t e4, e1;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic fmodel(int m, logic x, logic y, logic z);
    int s;
    s = int'(x) + int'(y) + int'(z);
    case (m)
      1: return x | y | z;
      2: return 1'b0;
      3: return 1'b1;
      default: return s >= 2;
    endcase
  endfunction

  function automatic exp_t model(int m);
    exp_t e;
    logic [2:0] v;
    e.err = 0;
    e.ff = 0;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      if (fmodel(m, v[2], v[1], v[0]) != fmodel(0, v[2], v[1], v[0])) begin
        if (e.err == 0) e.ff = v;
        e.err = e.err + 1;
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  assign f4 = fmodel(mode, x4, y4, z4);
  assign f1 = fmodel(mode, x1, y1, z1);

  maj_sweep_ctrl #(.DWELL(4), .CNT_W(8)) dut4 (
    .Clk(clk), .Rst_n(rst_n), .Start(start4), .F_i(f4),
    .X_o(x4), .Y_o(y4), .Z_o(z4), .Busy(busy4), .Done(done4),
    .Pass(pass4), .ErrCnt(err4), .FirstFail(ff4)
  );

  maj_sweep_ctrl #(.DWELL(1), .CNT_W(2)) dut1 (
    .Clk(clk), .Rst_n(rst_n), .Start(start1), .F_i(f1),
    .X_o(x1), .Y_o(y1), .Z_o(z1), .Busy(busy1), .Done(done1),
    .Pass(pass1), .ErrCnt(err1), .FirstFail(ff1)
  );

  always @(negedge clk) begin
    if (!busy4) bc4 = 0;
    else bc4++;
    if (busy4 && !done4) chk("vec4", {29'b0, x4, y4, z4}, (bc4 - 1) / 4);
    if (done4) begin
      ndone4++;
      chk("busy_len4", bc4, 33);
      if (q4.size() == 0) begin
        chk("spurious_done4", 1, 0);
      end else begin
        e4 = q4.pop_front();
        @(negedge clk);
        bc4 = 0;
        chk("idle_after4", busy4, 0);
        chk("err4", err4, e4.err);
        chk("ff4", ff4, e4.ff);
        chk("pass4", pass4, e4.pass);
        chk("xyz_hold4", {x4, y4, z4}, 7);
      end
    end
  end

  always @(negedge clk) begin
    if (!busy1) bc1 = 0;
    else bc1++;
    if (busy1 && !done1) chk("vec1", {29'b0, x1, y1, z1}, bc1 - 1);
    if (done1) begin
      ndone1++;
      chk("busy_len1", bc1, 9);
      if (q1.size() == 0) begin
        chk("spurious_done1", 1, 0);
      end else begin
        e1 = q1.pop_front();
        @(negedge clk);
        bc1 = 0;
        chk("err1", err1, e1.err);
        chk("ff1", ff1, e1.ff);
        chk("pass1", pass1, e1.pass);
      end
    end
  end

  task automatic drain();
    int i;
    for (i = 0; i < 300; i++) begin
      if (q4.size() == 0 && q1.size() == 0 && !busy4 && !busy1) break;
      @(negedge clk);
    end
    chk("drain_timeout", i < 300, 1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic sweep4(input int m);
    mode = m;
    q4.push_back(model(m));
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    drain();
  endtask

  task automatic sweep1(input int m);
    mode = m;
    q1.push_back(model(m));
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    drain();
  endtask

  task automatic wait_done4(output bit ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done4) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int base;
    repeat (3) @(negedge clk);
    chk("rst_state4", {x4, y4, z4, busy4, done4, pass4, err4, ff4}, 0);
    chk("rst_state1", {x1, y1, z1, busy1, done1, pass1, err1, ff1}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    sweep4(0);
    sweep4(1);
    sweep4(2);
    sweep4(3);

    // extra Start pulses mid-sweep must not start another sweep
    base = ndone4;
    mode = 0;
    q4.push_back(model(0));
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (10) @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (12) @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    drain();
    chk("ignored_start", ndone4 - base, 1);

    // Start held high: three back-to-back sweeps
    base = ndone4;
    mode = 0;
    repeat (3) q4.push_back(model(0));
    @(negedge clk);
    start4 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_done4(ok);
      chk("held_done", ok, 1);
      @(negedge clk);
      chk("held_gap_idle", busy4, 0);
      @(negedge clk);
      chk("held_rearm", busy4, 1);
    end
    start4 = 1'b0;
    drain();
    chk("held_count", ndone4 - base, 3);

    // async reset during vector 5 aborts with no Done
    base = ndone4;
    mode = 0;
    q4.push_back(model(0));
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy4 && {x4, y4, z4} == 3'd5) begin
        ok = 1;
        break;
      end
    end
    chk("find_vec5", ok, 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", {x4, y4, z4, busy4, done4, pass4, err4, ff4}, 0);
    q4.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_done_abort", ndone4 - base, 0);
    sweep4(0);

    sweep1(0);
    sweep1(2);
    sweep1(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
